// File: rtl/ofdm_pkg.sv
// Constants and types shared by the OFDM scrambler and descrambler.
package ofdm_pkg;

    localparam int unsigned SERVICE_LEN = 16;
    localparam int unsigned ACQ_LEN     = 7;
    localparam int unsigned LFSR_W      = 7;
    localparam int unsigned TAP_HI      = 6;
    localparam int unsigned TAP_LO      = 3;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SERV = 2'd2,
        ST_DATA = 2'd3
    } descram_fsm_e;

endpackage

// File: rtl/scram_lfsr7.sv
// Combinational step of the x^7+x^4+1 scrambler LFSR; shared by TX and RX.
module scram_lfsr7
    import ofdm_pkg::*;
(
    input  logic [LFSR_W-1:0] lfsr_state,
    output logic              feedback_c,
    output logic [LFSR_W-1:0] lfsr_next_c
);

    assign feedback_c  = lfsr_state[TAP_HI] ^ lfsr_state[TAP_LO];
    assign lfsr_next_c = {lfsr_state[LFSR_W-2:0], feedback_c};

endmodule

// File: rtl/data_descramble.sv
// Frame descrambler: recovers the scrambler state from the zero SERVICE bits,
// then descrambles the rest of the frame with one cycle of latency.
module data_descramble
    import ofdm_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              descram_start,
    input  logic [CNT_W-1:0]  descram_nbits,
    input  logic              descram_din,
    input  logic              descram_valid_i,
    output logic              descram_dout,
    output logic              descram_valid_o,
    output logic [LFSR_W-1:0] descram_state_o,
    output logic              descram_lock,
    output logic              descram_done,
    output logic              descram_err
);

    descram_fsm_e      fsm_q, fsm_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  nbits_q, nbits_d;
    logic              dout_d, valid_d, lock_d, done_d, err_d;

    logic              fb_c;
    logic [LFSR_W-1:0] lfsr_next_c;
    logic [LFSR_W-1:0] acq_shift_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              last_bit_c;

    scram_lfsr7 u_lfsr (
        .lfsr_state  (lfsr_q),
        .feedback_c  (fb_c),
        .lfsr_next_c (lfsr_next_c)
    );

    assign acq_shift_c = {lfsr_q[LFSR_W-2:0], descram_din};
    assign cnt_inc_c   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign last_bit_c  = (cnt_q == nbits_q - CNT_W'(1));

    // Next-state and output decode; start takes priority over everything.
    always_comb begin
        fsm_d   = fsm_q;
        lfsr_d  = lfsr_q;
        state_d = descram_state_o;
        cnt_d   = cnt_q;
        nbits_d = nbits_q;
        lock_d  = descram_lock;
        err_d   = descram_err;
        dout_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (descram_start) begin
            nbits_d = descram_nbits;
            cnt_d   = '0;
            lock_d  = 1'b0;
            err_d   = 1'b0;
            if (descram_nbits < CNT_W'(SERVICE_LEN)) begin
                err_d = 1'b1;
                fsm_d = ST_IDLE;
            end else begin
                fsm_d = ST_ACQ;
                if (descram_valid_i) begin
                    lfsr_d  = acq_shift_c;
                    cnt_d   = CNT_W'(1);
                    valid_d = 1'b1;
                end
            end
        end else if (descram_valid_i) begin
            case (fsm_q)
                ST_ACQ: begin
                    // Transmitted SERVICE bits are zero, so received bits are the scrambler sequence.
                    lfsr_d  = acq_shift_c;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc_c;
                    if (cnt_q == CNT_W'(ACQ_LEN - 1)) begin
                        state_d = acq_shift_c;
                        lock_d  = 1'b1;
                        fsm_d   = ST_SERV;
                    end
                end
                ST_SERV, ST_DATA: begin
                    lfsr_d  = lfsr_next_c;
                    dout_d  = descram_din ^ fb_c;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc_c;
                    if (fsm_q == ST_SERV && dout_d) begin
                        err_d = 1'b1;
                    end
                    if (last_bit_c) begin
                        done_d = 1'b1;
                        lock_d = 1'b0;
                        fsm_d  = ST_IDLE;
                    end else if (fsm_q == ST_SERV && cnt_q == CNT_W'(SERVICE_LEN - 1)) begin
                        fsm_d = ST_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            fsm_q           <= ST_IDLE;
            lfsr_q          <= '0;
            descram_state_o <= '0;
            cnt_q           <= '0;
            nbits_q         <= '0;
            descram_dout    <= 1'b0;
            descram_valid_o <= 1'b0;
            descram_lock    <= 1'b0;
            descram_done    <= 1'b0;
            descram_err     <= 1'b0;
        end else begin
            fsm_q           <= fsm_d;
            lfsr_q          <= lfsr_d;
            descram_state_o <= state_d;
            cnt_q           <= cnt_d;
            nbits_q         <= nbits_d;
            descram_dout    <= dout_d;
            descram_valid_o <= valid_d;
            descram_lock    <= lock_d;
            descram_done    <= done_d;
            descram_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_data_descramble.sv
// Scoreboard bench for data_descramble: a TX scrambler model feeds frames and
// queues the expected descrambled bits, flags and recovered state.
module tb_data_descramble;

    logic        sys_clk;
    logic        sys_rstn;
    logic        descram_start;
    logic [15:0] descram_nbits;
    logic        descram_din;
    logic        descram_valid_i;
    logic        descram_dout;
    logic        descram_valid_o;
    logic [6:0]  descram_state_o;
    logic        descram_lock;
    logic        descram_done;
    logic        descram_err;

    typedef struct packed {
        logic       dout;
        logic       done;
        logic       err;
        logic       lock;
        logic       schk;
        logic [6:0] st;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_vo   = 1'b0;
    logic exp_vo_q = 1'b0;
    logic [6:0] cur_st = '0;
    logic st_known = 1'b0;

    logic       orig [0:127];
    logic [6:0] tx_s;
    logic [6:0] st7;
    logic       err_acc;
    int         cur_nbits;

    data_descramble dut (
        .sys_clk         (sys_clk),
        .sys_rstn        (sys_rstn),
        .descram_start   (descram_start),
        .descram_nbits   (descram_nbits),
        .descram_din     (descram_din),
        .descram_valid_i (descram_valid_i),
        .descram_dout    (descram_dout),
        .descram_valid_o (descram_valid_o),
        .descram_state_o (descram_state_o),
        .descram_lock    (descram_lock),
        .descram_done    (descram_done),
        .descram_err     (descram_err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge sys_clk) exp_vo_q <= exp_vo;

    // Output monitor: every cycle valid_o must follow the driven qualifier by one cycle.
    always @(negedge sys_clk) begin
        check_eq("valid_o", 16'(descram_valid_o), 16'(exp_vo_q));
        if (descram_valid_o) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 16'(descram_valid_o), 16'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("dout", 16'(descram_dout), 16'(mon_e.dout));
                check_eq("done", 16'(descram_done), 16'(mon_e.done));
                check_eq("err",  16'(descram_err),  16'(mon_e.err));
                check_eq("lock", 16'(descram_lock), 16'(mon_e.lock));
                if (mon_e.schk) begin
                    check_eq("state_o", 16'(descram_state_o), 16'(mon_e.st));
                    cur_st   = mon_e.st;
                    st_known = 1'b1;
                end
            end
        end else begin
            check_eq("done_no_valid", 16'(descram_done), 16'd0);
            if (descram_lock && st_known)
                check_eq("state_hold", 16'(descram_state_o), 16'(cur_st));
        end
    end

    task automatic build(input int nbits, input int bad_idx);
        for (int i = 0; i < nbits; i++)
            orig[i] = (i < 16) ? (i == bad_idx) : 1'($urandom_range(0, 1));
    endtask

    // TX scrambler model for one bit, plus the matching scoreboard entry.
    task automatic put_bit(input int i);
        sb_t  e;
        logic f;
        f               = tx_s[6] ^ tx_s[3];
        descram_din     = orig[i] ^ f;
        descram_valid_i = 1'b1;
        exp_vo          = 1'b1;
        tx_s            = {tx_s[5:0], f};
        if (i == 6) st7 = tx_s;
        if (i >= 7 && i < 16 && orig[i]) err_acc = 1'b1;
        e.dout = orig[i];
        e.done = (i == cur_nbits - 1);
        e.err  = err_acc;
        e.lock = (i >= 6) && (i != cur_nbits - 1);
        e.schk = (i >= 6);
        e.st   = st7;
        sb.push_back(e);
    endtask

    task automatic idle_cycle(input logic vi);
        @(posedge sys_clk); #1;
        descram_start   = 1'b0;
        descram_valid_i = vi;
        descram_din     = 1'($urandom_range(0, 1));
        exp_vo          = 1'b0;
    endtask

    task automatic run_frame(input logic [6:0] seed, input int nbits, input int bad_idx,
                             input bit gaps, input int stop_at, input bit bit_on_start,
                             input bit chain);
        int first;
        build(nbits, bad_idx);
        tx_s      = seed;
        st7       = '0;
        err_acc   = 1'b0;
        cur_nbits = nbits;
        @(posedge sys_clk); #1;
        descram_start = 1'b1;
        descram_nbits = 16'(nbits);
        if (bit_on_start) begin
            put_bit(0);
            first = 1;
        end else begin
            descram_valid_i = 1'b0;
            exp_vo          = 1'b0;
            first           = 0;
        end
        for (int i = first; i < stop_at; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle_cycle(1'b0);
            @(posedge sys_clk); #1;
            descram_start = 1'b0;
            put_bit(i);
        end
        if (!chain) idle_cycle(1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rstn        = 1'b0;
        descram_start   = 1'b0;
        descram_nbits   = '0;
        descram_din     = 1'b0;
        descram_valid_i = 1'b0;
        #2;
        check_eq("rst_valid_o", 16'(descram_valid_o), 16'd0);
        check_eq("rst_lock",    16'(descram_lock),    16'd0);
        check_eq("rst_err",     16'(descram_err),     16'd0);
        check_eq("rst_state_o", 16'(descram_state_o), 16'd0);
        @(posedge sys_clk); #3;
        sys_rstn = 1'b1;

        // Nominal 80-bit frame.
        run_frame(7'b1011101, 80, -1, 1'b0, 80, 1'b0, 1'b0);
        // All-ones seed with random input gaps.
        run_frame(7'h7F, 80, -1, 1'b1, 80, 1'b0, 1'b0);
        // Non-zero reserved SERVICE bit 10.
        run_frame(7'h29, 80, 10, 1'b0, 80, 1'b0, 1'b0);
        check_eq("err_sticky", 16'(descram_err), 16'd1);

        // SERVICE-only frame; following valid bits must be ignored.
        run_frame(7'h11, 16, -1, 1'b0, 16, 1'b0, 1'b0);
        repeat (4) idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Too-short frame: error, no output.
        @(posedge sys_clk); #1;
        descram_start   = 1'b1;
        descram_nbits   = 16'd8;
        descram_valid_i = 1'b0;
        exp_vo          = 1'b0;
        idle_cycle(1'b1);
        @(negedge sys_clk);
        check_eq("short_err",  16'(descram_err),  16'd1);
        check_eq("short_lock", 16'(descram_lock), 16'd0);
        repeat (3) idle_cycle(1'b1);
        idle_cycle(1'b0);
        @(negedge sys_clk);
        check_eq("short_err_hold", 16'(descram_err), 16'd1);

        // Abort at bit 40; the restart cycle carries bit 0 of the new frame.
        run_frame(7'h55, 80, -1, 1'b0, 40, 1'b0, 1'b1);
        run_frame(7'h33, 80, -1, 1'b0, 80, 1'b1, 1'b0);

        // Asynchronous reset in the DATA phase.
        run_frame(7'h4C, 80, -1, 1'b0, 30, 1'b0, 1'b0);
        check_eq("pre_rst_lock", 16'(descram_lock), 16'd1);
        @(posedge sys_clk); #3;
        sys_rstn = 1'b0;
        #1;
        check_eq("arst_dout",    16'(descram_dout),    16'd0);
        check_eq("arst_valid_o", 16'(descram_valid_o), 16'd0);
        check_eq("arst_lock",    16'(descram_lock),    16'd0);
        check_eq("arst_done",    16'(descram_done),    16'd0);
        check_eq("arst_err",     16'(descram_err),     16'd0);
        check_eq("arst_state_o", 16'(descram_state_o), 16'd0);
        check_eq("sb_drain_rst", 16'(sb.size()),       16'd0);
        repeat (2) @(posedge sys_clk);
        #3;
        sys_rstn = 1'b1;
        repeat (3) idle_cycle(1'b1);
        run_frame(7'h2A, 80, -1, 1'b0, 80, 1'b0, 1'b0);

        repeat (3) idle_cycle(1'b0);
        check_eq("sb_drain_end", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_descramble.md
DATA_DESCRAMBLE -- requirements
Module: data_descramble

Interface
REQ-001 The block SHALL have the port sys_clk, input, width 1: single rising-edge clock for all state.
REQ-002 The block SHALL have the port sys_rstn, input, width 1: reset, asynchronous assert, active-low.
REQ-003 The block SHALL have the port descram_start, input, width 1: one-cycle frame-start pulse, sampled with the frame length.
REQ-004 The block SHALL have the port descram_nbits, input, width 16: total frame bits including the 16 SERVICE bits, sampled on descram_start.
REQ-005 The block SHALL have the port descram_din, input, width 1: received scrambled bit.
REQ-006 The block SHALL have the port descram_valid_i, input, width 1: descram_din qualifier; gaps allowed.
REQ-007 The block SHALL have the port descram_dout, output, width 1: descrambled bit.
REQ-008 The block SHALL have the port descram_valid_o, output, width 1: descram_dout qualifier.
REQ-009 The block SHALL have the port descram_state_o, output, width 7: recovered scrambler state, frozen after acquisition.
REQ-010 The block SHALL have the port descram_lock, output, width 1: high from acquisition complete until frame end.
REQ-011 The block SHALL have the port descram_done, output, width 1: one-cycle pulse coincident with the last frame bit on the output.
REQ-012 The block SHALL have the port descram_err, output, width 1: sticky per frame; set on non-zero reserved SERVICE bits or descram_nbits < 16.

Function
REQ-013 The block SHALL use the polynomial x^7+x^4+1, with feedback f = s[6] XOR s[3].
REQ-014 The block SHALL implement the states IDLE, ACQ, SERV and DATA.
REQ-015 In IDLE, the block SHALL ignore descram_valid_i and keep all outputs low except descram_state_o.
REQ-016 On descram_start, the block SHALL latch descram_nbits, clear the bit counter, lock and err, and enter ACQ.
REQ-017 On descram_start with descram_nbits < 16, the block SHALL set err and return to IDLE with no output bits.
REQ-018 In ACQ (SERVICE bits 0..6, transmitted as zeros), each valid bit SHALL shift in as s <= {s[5:0], din} and SHALL be output as 0.
REQ-019 After the 7th valid ACQ bit, s SHALL equal the transmit scrambler state; the block SHALL load descram_state_o, assert lock and enter SERV.
REQ-020 In SERV and DATA, each valid bit SHALL produce dout = din XOR f, with the state advancing as s <= {s[5:0], f}.
REQ-021 In SERV (bits 7..15), any dout = 1 SHALL set err; the frame SHALL still complete.
REQ-022 After bit 15, the block SHALL enter DATA, or IDLE if descram_nbits = 16.
REQ-023 In DATA, the block SHALL count bits to descram_nbits-1; on the last valid bit it SHALL pulse done and go to IDLE with lock deasserted the following cycle.
REQ-024 Latency SHALL be exactly 1 cycle: valid_o, dout and done are registered from the same-cycle descram_valid_i and descram_din.
REQ-025 When valid_i is low, valid_o SHALL be low, and state and counter SHALL hold.
REQ-026 descram_start in any non-IDLE state SHALL abort the current frame without a done pulse and restart per REQ-016; a valid bit in the same cycle SHALL be treated as bit 0 of the new frame.
REQ-027 descram_err SHALL hold until the next descram_start.
REQ-028 The bit counter SHALL be 16 bits and SHALL NOT wrap within a frame.

Reset
REQ-029 On sys_rstn low, the block SHALL asynchronously set the state to IDLE, s and descram_state_o to 0, and the counter, length latch, dout, valid_o, lock, done and err to 0.
REQ-030 Reset deassertion mid-frame SHALL leave the block in IDLE, waiting for descram_start.

Structure
REQ-031 A shared package ofdm_pkg SHALL hold the FSM state typedef, SERVICE_LEN=16, ACQ_LEN=7 and the tap indices 6 and 3, so they are common with the transmit scrambler.
REQ-032 An optional sub-module scram_lfsr7 SHALL provide the combinational next-state and feedback function, reusable by the transmitter; the FSM and counter SHALL remain in data_descramble.

Verification
REQ-033 The bench SHALL apply: seed 7'b1011101, 16 zero SERVICE bits plus 64 random data bits through a bench TX scrambler model, descram_nbits=80 -> dout equals the original bits, descram_state_o = state after 7 bits, done at output bit 80, err=0.
REQ-034 The bench SHALL apply: all-ones seed with random valid_i gaps (50% duty) -> identical output sequence, valid_o strictly 1 cycle after each valid_i, state frozen during gaps.
REQ-035 The bench SHALL apply: SERVICE bit 10 set to 1 before scrambling -> err=1 from that output bit, frame completes, done pulses.
REQ-036 The bench SHALL apply: descram_nbits=16 -> done on the 16th output bit and no DATA state; descram_nbits=8 -> err=1, immediate return to IDLE, no valid_o.
REQ-037 The bench SHALL apply: descram_start issued at bit 40 of an 80-bit frame -> no done for the first frame, lock drops, second frame decodes correctly from bit 0.
REQ-038 The bench SHALL apply: sys_rstn pulsed low at DATA bit 30 -> all outputs 0 asynchronously; a following frame decodes correctly.
